// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, byte-addressed data memory between the core MEM stage
// (port C) and a debug/bench port (port D).
//
// Each cycle at most one requester is granted. The grant drives the memory strobe, word address,
// byte enables and lane-replicated store data in the same cycle. Load data returns one cycle after
// the grant, extracted from the addressed lanes and sign- or zero-extended according to funct3.
// A misaligned access or an illegal funct3 is still granted, but the memory is left untouched.
// err then pulses for one cycle, and a load also returns rvalid with zero data.
//
// Configuration macro: DMEM_ARB_RR_EN
//   defined   : round-robin between C and D on conflict (MAX_WAIT unused)
//   undefined : C has fixed priority; D takes priority after MAX_WAIT consecutive denied cycles
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   c_*/d_* req,we,f3,addr,wdata   requester inputs (f3: 000 B, 001 H, 010 W, 100 BU, 101 HU)
//   c_gnt/d_gnt              combinational grant
//   c_rvalid/d_rvalid        load data valid, one cycle after grant
//   c_rdata/d_rdata          extended load data
//   c_stall                  core request not granted this cycle
//   m_en,m_we,m_be,m_addr,m_wdata   memory request
//   m_rdata                  memory read word, valid one cycle after m_en
//   err                      one-cycle pulse after a misaligned or illegal access
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [2:0]        c_f3,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_f3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              c_gnt,
  output logic              d_gnt,
  output logic              c_rvalid,
  output logic              d_rvalid,
  output logic [31:0]       c_rdata,
  output logic [31:0]       d_rdata,
  output logic              c_stall,
  output logic              m_en,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-3:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              err
);

  logic d_win;

`ifdef DMEM_ARB_RR_EN
  // rr_last_q: 1 = D was granted last, 0 = C was granted last.
  logic rr_last_q, rr_last_d;

  assign d_win = d_req & (~c_req | ~rr_last_q);

  always_comb begin
    rr_last_d = rr_last_q;
    if (c_gnt) begin
      rr_last_d = 1'b0;
    end else if (d_gnt) begin
      rr_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            d_aged;

  assign d_aged = (wait_cnt_q == CntW'(MAX_WAIT));
  assign d_win  = d_req & (~c_req | d_aged);

  // Counts consecutive denied cycles of D, saturating so D keeps priority once aged.
  always_comb begin
    wait_cnt_d = '0;
    if (d_req && !d_gnt) begin
      wait_cnt_d = d_aged ? wait_cnt_q : wait_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  // Grants are suppressed during reset so every output is quiet while rst is high.
  assign d_gnt   = d_win & ~rst;
  assign c_gnt   = c_req & ~d_win & ~rst;
  assign c_stall = c_req & ~c_gnt & ~rst;

  // Winner's request; zero when nothing is granted.
  logic              any_gnt;
  logic              sel_we;
  logic [2:0]        sel_f3;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [1:0]        sel_off;

  assign any_gnt = c_gnt | d_gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_f3    = 3'b000;
    sel_addr  = '0;
    sel_wdata = '0;
    if (d_gnt) begin
      sel_we    = d_we;
      sel_f3    = d_f3;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end else if (c_gnt) begin
      sel_we    = c_we;
      sel_f3    = c_f3;
      sel_addr  = c_addr;
      sel_wdata = c_wdata;
    end
  end

  assign sel_off = sel_addr[1:0];

  logic       illegal;
  logic [3:0] be;

  always_comb begin
    illegal = 1'b0;
    unique case (sel_f3)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = sel_off[0];
      3'b010:         illegal = (sel_off != 2'b00);
      default:        illegal = 1'b1;
    endcase
  end

  always_comb begin
    be      = 4'b1111;
    m_wdata = sel_wdata;
    unique case (sel_f3[1:0])
      2'b00: begin
        be      = 4'b0001 << sel_off;
        m_wdata = {4{sel_wdata[7:0]}};
      end
      2'b01: begin
        be      = 4'b0011 << sel_off;
        m_wdata = {2{sel_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        m_wdata = sel_wdata;
      end
    endcase
  end

  assign m_en   = any_gnt & ~illegal;
  assign m_we   = m_en & sel_we;
  assign m_be   = m_en ? be : 4'b0000;
  assign m_addr = sel_addr[ADDR_W-1:2];

  // Read-return record: who owns the data arriving next cycle and how to extract it.
  logic       rd_valid_q, rd_valid_d;
  logic       rd_owner_q, rd_owner_d; // 1 = D
  logic [2:0] rd_f3_q, rd_f3_d;
  logic [1:0] rd_off_q, rd_off_d;
  logic       rd_err_q, rd_err_d;
  logic       err_q, err_d;

  always_comb begin
    rd_valid_d = any_gnt & ~sel_we;
    rd_owner_d = d_gnt;
    rd_f3_d    = sel_f3;
    rd_off_d   = sel_off;
    rd_err_d   = illegal;
    err_d      = any_gnt & illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_f3_q    <= 3'b000;
      rd_off_q   <= 2'b00;
      rd_err_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
      rd_f3_q    <= rd_f3_d;
      rd_off_q   <= rd_off_d;
      rd_err_q   <= rd_err_d;
      err_q      <= err_d;
    end
  end

  logic [31:0] lane;
  logic [31:0] rdata_ext;
  logic        rvalid_live;

  assign lane = m_rdata >> {rd_off_q, 3'b000};

  always_comb begin
    rdata_ext = m_rdata;
    unique case (rd_f3_q)
      3'b000:  rdata_ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  rdata_ext = {24'h000000, lane[7:0]};
      3'b001:  rdata_ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  rdata_ext = {16'h0000, lane[15:0]};
      default: rdata_ext = m_rdata;
    endcase
    if (rd_err_q) begin
      rdata_ext = '0;
    end
  end

  // A read pending when reset arrives is dropped immediately.
  assign rvalid_live = rd_valid_q & ~rst;
  assign c_rvalid    = rvalid_live & ~rd_owner_q;
  assign d_rvalid    = rvalid_live & rd_owner_q;
  assign c_rdata     = c_rvalid ? rdata_ext : 32'h0;
  assign d_rdata     = d_rvalid ? rdata_ext : 32'h0;
  assign err         = err_q & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a small word memory answers the memory port, and expected
// load returns are queued at grant time and compared when rvalid appears.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [2:0]  c_f3, d_f3;
  logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
  logic        c_gnt, d_gnt, c_rvalid, d_rvalid, c_stall;
  logic [31:0] c_rdata, d_rdata;
  logic        m_en, m_we, err;
  logic [3:0]  m_be;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        owner; // 1 = D
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  dmem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_f3     (c_f3),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_f3     (d_f3),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .c_gnt    (c_gnt),
    .d_gnt    (d_gnt),
    .c_rvalid (c_rvalid),
    .d_rvalid (d_rvalid),
    .c_rdata  (c_rdata),
    .d_rdata  (d_rdata),
    .c_stall  (c_stall),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Word memory, byte k preloaded with value k except for a few marked words.
  logic [31:0] mem [0:63];
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
      end
      mem[0]   <= 32'h8081F0F1;
      mem[2]   <= 32'hCAFEBABE;
      mem[5]   <= 32'h11FE2233;
      mem_init <= 1'b1;
    end else if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++) begin
          if (m_be[b]) mem[m_addr[5:0]][8*b +: 8] <= m_wdata[8*b +: 8];
        end
      end else begin
        m_rdata <= mem[m_addr[5:0]];
      end
    end
  end

  task automatic set_c(input logic req, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    c_req = req; c_we = we; c_f3 = f3; c_addr = addr; c_wdata = wdata;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    d_req = req; d_we = we; d_f3 = f3; d_addr = addr; d_wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard whenever a load return is presented.
  task automatic monitor();
    exp_t        e;
    logic        got_owner;
    logic [31:0] got_data;
    forever begin
      @(negedge clk);
      if (!rst && (c_rvalid || d_rvalid)) begin
        checks++;
        got_owner = d_rvalid;
        got_data  = d_rvalid ? d_rdata : c_rdata;
        if (c_rvalid && d_rvalid) begin
          errors++;
          $display("FAIL rvalid_both: c_rvalid=1 d_rvalid=1, required only one");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected: owner=%0d data=%h, required no return", got_owner,
                   got_data);
        end else begin
          e = exp_q.pop_front();
          if (got_owner !== e.owner || got_data !== e.data) begin
            errors++;
            $display("FAIL rvalid_return: owner=%0d data=%h, required owner=%0d data=%h",
                     got_owner, got_data, e.owner, e.data);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_c(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if ({c_gnt, d_gnt, c_rvalid, d_rvalid, c_stall, m_en, m_we, err, m_be} !== 12'h000 ||
        c_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b c_rdata=%h d_rdata=%h, required all zero",
               {c_gnt, d_gnt, c_rvalid, d_rvalid, c_stall, m_en, m_we, err, m_be}, c_rdata,
               d_rdata);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_store();
    next_cycle();
    set_c(1'b1, 1'b1, 3'b010, 32'h04, 32'h0F0F070D);
    @(negedge clk);
    checks++;
    if ({c_gnt, c_stall, m_en, m_we, m_be} !== 8'b1011_1111 || m_addr !== 30'd1 ||
        m_wdata !== 32'h0F0F070D) begin
      errors++;
      $display("FAIL store_sw_issue: ctl=%b addr=%h wdata=%h, required 10111111 1 0f0f070d",
               {c_gnt, c_stall, m_en, m_we, m_be}, m_addr, m_wdata);
    end
    next_cycle();
    set_c(1'b1, 1'b1, 3'b000, 32'h07, 32'h000000AB);
    @(negedge clk);
    checks++;
    if (mem[1] !== 32'h0F0F070D) begin
      errors++;
      $display("FAIL store_sw_mem: got %h required 0f0f070d", mem[1]);
    end
    checks++;
    if (m_be !== 4'b1000 || m_wdata !== 32'hABABABAB || m_addr !== 30'd1) begin
      errors++;
      $display("FAIL store_sb_issue: be=%b wdata=%h addr=%h, required 1000 abababab 1", m_be,
               m_wdata, m_addr);
    end
    next_cycle();
    set_c(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (mem[1] !== 32'hAB0F070D || c_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL store_sb_mem: mem=%h rvalid=%b, required ab0f070d 0", mem[1], c_rvalid);
    end
  endtask

  task automatic test_load();
    logic [2:0]  f3s  [5];
    logic [31:0] adrs [5];
    logic [31:0] exps [5];
    f3s  = '{3'b000, 3'b100, 3'b001, 3'b001, 3'b101};
    adrs = '{32'h16, 32'h16, 32'h16, 32'h00, 32'h02};
    exps = '{32'hFFFFFFFE, 32'h000000FE, 32'h000011FE, 32'hFFFFF0F1, 32'h00008081};
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      set_c(1'b1, 1'b0, f3s[i], adrs[i], 32'h0);
      @(negedge clk);
      exp_q.push_back('{owner: 1'b0, data: exps[i]});
      checks++;
      if ({c_gnt, m_en, m_we} !== 3'b110 || m_addr !== 30'(adrs[i] >> 2) ||
          (i > 0 && c_rvalid !== 1'b1)) begin
        errors++;
        $display("FAIL load_issue_%0d: gnt/en/we=%b addr=%h rvalid=%b", i, {c_gnt, m_en, m_we},
                 m_addr, c_rvalid);
      end
    end
    checks++;
    if (m_be !== 4'b1100) begin
      errors++;
      $display("FAIL load_hu_be: got %b required 1100", m_be);
    end
    next_cycle();
    set_c(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    next_cycle();
  endtask

  task automatic test_error();
    next_cycle();
    set_c(1'b1, 1'b1, 3'b001, 32'h15, 32'h0000FFFE);
    @(negedge clk);
    checks++;
    if ({c_gnt, m_en, err} !== 3'b100) begin
      errors++;
      $display("FAIL err_sh_issue: gnt/en/err=%b required 100", {c_gnt, m_en, err});
    end
    next_cycle();
    set_c(1'b1, 1'b0, 3'b010, 32'h02, 32'h0);
    @(negedge clk);
    exp_q.push_back('{owner: 1'b0, data: 32'h0});
    checks++;
    if ({c_gnt, m_en, err} !== 3'b101) begin
      errors++;
      $display("FAIL err_lw_issue: gnt/en/err=%b required 101", {c_gnt, m_en, err});
    end
    next_cycle();
    set_c(1'b1, 1'b0, 3'b011, 32'h00, 32'h0);
    @(negedge clk);
    exp_q.push_back('{owner: 1'b0, data: 32'h0});
    checks++;
    if ({c_gnt, m_en, err} !== 3'b101) begin
      errors++;
      $display("FAIL err_f3_issue: gnt/en/err=%b required 101", {c_gnt, m_en, err});
    end
    next_cycle();
    set_c(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_f3_pulse: got %b required 1", err);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || mem[5] !== 32'h11FE2233) begin
      errors++;
      $display("FAIL err_clear_mem: err=%b mem=%h, required 0 11fe2233", err, mem[5]);
    end
  endtask

  task automatic test_aging(input bit after_reset);
    logic prev_d = 1'b0;
    next_cycle();
    set_c(1'b1, 1'b1, 3'b010, 32'h20, 32'h11111111);
    set_d(1'b1, 1'b1, 3'b010, 32'h24, 32'h22222222);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      checks++;
`ifdef DMEM_ARB_RR_EN
      if ((c_gnt ^ d_gnt) !== 1'b1 || c_stall !== d_gnt || (cyc > 1 && d_gnt === prev_d) ||
          (after_reset && cyc == 1 && c_gnt !== 1'b1)) begin
        errors++;
        $display("FAIL rr_cycle_%0d: c_gnt=%b d_gnt=%b stall=%b prev_d=%b", cyc, c_gnt, d_gnt,
                 c_stall, prev_d);
      end
`else
      if (d_gnt !== (cyc % 5 == 0) || c_gnt !== (cyc % 5 != 0) || c_stall !== (cyc % 5 == 0))
      begin
        errors++;
        $display("FAIL aging_cycle_%0d: c_gnt=%b d_gnt=%b stall=%b, required d_gnt=%0d", cyc,
                 c_gnt, d_gnt, c_stall, (cyc % 5 == 0));
      end
`endif
      prev_d = d_gnt;
      next_cycle();
    end
    set_c(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checks++;
    if (after_reset && mem[9] !== 32'h22222222) begin
      errors++;
      $display("FAIL aging_d_store: got %h required 22222222", mem[9]);
    end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    set_c(1'b1, 1'b0, 3'b010, 32'h00, 32'h0);
    @(negedge clk);
    exp_q.push_back('{owner: 1'b0, data: 32'h8081F0F1});
    next_cycle();
    set_c(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_d(1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
    @(negedge clk);
    exp_q.push_back('{owner: 1'b1, data: 32'hCAFEBABE});
    checks++;
    if ({d_gnt, c_rvalid} !== 2'b11 || c_rdata !== 32'h8081F0F1) begin
      errors++;
      $display("FAIL b2b_c_then_d: d_gnt/c_rvalid=%b c_rdata=%h, required 11 8081f0f1",
               {d_gnt, c_rvalid}, c_rdata);
    end
    next_cycle();
    set_c(1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
    set_d(1'b1, 1'b0, 3'b010, 32'h00, 32'h0);
    @(negedge clk);
    exp_q.push_back('{owner: 1'b0, data: 32'hCAFEBABE});
    checks++;
    if ({c_gnt, d_gnt, d_rvalid} !== 3'b101 || d_rdata !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL b2b_conflict: c/d gnt,d_rvalid=%b d_rdata=%h, required 101 cafebabe",
               {c_gnt, d_gnt, d_rvalid}, d_rdata);
    end
    next_cycle();
    set_c(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    exp_q.push_back('{owner: 1'b1, data: 32'h8081F0F1});
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL b2b_d_after_conflict: d_gnt=%b required 1", d_gnt);
    end
    next_cycle();
    set_d(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    next_cycle();
  endtask

  task automatic test_reset_drop();
    next_cycle();
    set_c(1'b1, 1'b1, 3'b010, 32'h20, 32'h33333333);
    set_d(1'b1, 1'b1, 3'b010, 32'h24, 32'h44444444);
    next_cycle();
    next_cycle();
    // Load whose return must be dropped by the reset that follows.
    set_c(1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
`ifdef DMEM_ARB_RR_EN
    set_d(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
`endif
    @(negedge clk);
    checks++;
    if (c_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstdrop_load_gnt: got %b required 1", c_gnt);
    end
    next_cycle();
    rst = 1'b1;
    set_c(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({c_rvalid, d_rvalid, err, m_en, d_gnt, c_stall} !== 6'b0 || c_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rstdrop_in_reset: rv/err/en/gnt/stall=%b c_rdata=%h, required zero",
               {c_rvalid, d_rvalid, err, m_en, d_gnt, c_stall}, c_rdata);
    end
    next_cycle();
    rst = 1'b0;
    set_d(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({c_rvalid, d_rvalid, err} !== 3'b000) begin
      errors++;
      $display("FAIL rstdrop_after: rv/err=%b required 000", {c_rvalid, d_rvalid, err});
    end
    test_aging(1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_store();
    test_load();
    test_error();
    test_aging(1'b0);
    test_back_to_back();
    test_reset_drop();
    repeat (2) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_returns: %0d outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
